// File: rtl/board_test_sequencer.sv
// -----------------------------------------------------------------------------
// board_test_sequencer
//
// Runs the board self-test units one after another. Each unit gets an init
// pulse, acknowledges by raising its progress line, and reports its result
// when progress falls. The sequencer bounds both phases with timeouts,
// latches per-channel pass/fail/timeout flags, and can loop runs for soak
// testing while counting completed and failing passes.
//
// Ports
//   clk_i             system clock
//   rst_i             synchronous active-high reset
//   start_i           1-cycle pulse, begin a run (ignored while busy)
//   abort_i           1-cycle pulse, stop the run and return to idle
//   loop_en_i         restart automatically after each run
//   test_mask_i       per-channel enable, sampled at the start of each run
//   test_progress_i   per-unit test_in_progress (asynchronous)
//   test_result_i     per-unit test_result, valid when progress falls
//   test_init_o       one-hot init pulse to the units
//   busy_o            high from start until the run ends
//   done_o            1-cycle pulse at the end of every run
//   cur_test_o        index of the channel being run
//   pass_flags_o      channel passed on its last run
//   fail_flags_o      channel failed or timed out on its last run
//   tmo_flags_o       channel timed out (ack or run)
//   loops_done_o      completed runs, saturating
//   loops_failed_o    runs with any fail flag set, saturating
// -----------------------------------------------------------------------------
module board_test_sequencer #(
  parameter int NTESTS    = 4,
  parameter int INIT_CYC  = 8,
  parameter int ACK_TMO   = 1024,
  parameter int RUN_TMO_W = 28,
  parameter int LOOPCNT_W = 16
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      start_i,
  input  logic                      abort_i,
  input  logic                      loop_en_i,
  input  logic [NTESTS-1:0]         test_mask_i,
  input  logic [NTESTS-1:0]         test_progress_i,
  input  logic [NTESTS-1:0]         test_result_i,
  output logic [NTESTS-1:0]         test_init_o,
  output logic                      busy_o,
  output logic                      done_o,
  output logic [$clog2(NTESTS)-1:0] cur_test_o,
  output logic [NTESTS-1:0]         pass_flags_o,
  output logic [NTESTS-1:0]         fail_flags_o,
  output logic [NTESTS-1:0]         tmo_flags_o,
  output logic [LOOPCNT_W-1:0]      loops_done_o,
  output logic [LOOPCNT_W-1:0]      loops_failed_o
);

  localparam int IDX_W  = $clog2(NTESTS);
  // One extra bit so the index can reach NTESTS, the end-of-run marker.
  localparam int IDXF_W = IDX_W + 1;
  localparam int CNT_MAX = (INIT_CYC > ACK_TMO) ? INIT_CYC : ACK_TMO;
  localparam int CNT_W  = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SCAN,
    S_LAUNCH,
    S_ACK,
    S_RUN,
    S_NEXT,
    S_DONE
  } state_e;

  // ---------------------------------------------------------------------------
  // Two-flop synchronisers for the asynchronous unit outputs. Progress and
  // result travel through identical stages so they stay aligned.
  // ---------------------------------------------------------------------------
  logic [NTESTS-1:0] prog_meta_q, prog_s_q;
  logic [NTESTS-1:0] res_meta_q, res_s_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value; blocking here would collapse the two sync stages.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      prog_meta_q <= '0;
      prog_s_q    <= '0;
      res_meta_q  <= '0;
      res_s_q     <= '0;
    end else begin
      prog_meta_q <= test_progress_i;
      prog_s_q    <= prog_meta_q;
      res_meta_q  <= test_result_i;
      res_s_q     <= res_meta_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Sequencer FSM with registered outputs
  // ---------------------------------------------------------------------------
  state_e                 state_q;
  logic [IDXF_W-1:0]      idx_q;
  logic [IDX_W-1:0]       cur_q;
  logic [NTESTS-1:0]      mask_q;
  logic [NTESTS-1:0]      init_q;
  logic [NTESTS-1:0]      pass_q, fail_q, tmo_q;
  logic [CNT_W-1:0]       cnt_q;
  logic [RUN_TMO_W-1:0]   run_cnt_q;
  logic [LOOPCNT_W-1:0]   loops_done_q, loops_failed_q;
  logic                   busy_q, done_q;

  logic [IDX_W-1:0]  idx_lo_d;
  logic [NTESTS-1:0] onehot_d;

  // Low index bits are only used while idx_q < NTESTS, so they are in range.
  assign idx_lo_d = idx_q[IDX_W-1:0];
  assign onehot_d = {{(NTESTS-1){1'b0}}, 1'b1} << idx_lo_d;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q        <= S_IDLE;
      idx_q          <= '0;
      cur_q          <= '0;
      mask_q         <= '0;
      init_q         <= '0;
      pass_q         <= '0;
      fail_q         <= '0;
      tmo_q          <= '0;
      cnt_q          <= '0;
      run_cnt_q      <= '0;
      loops_done_q   <= '0;
      loops_failed_q <= '0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (abort_i && state_q != S_IDLE) begin
        // Abort drops everything in flight; flags and loop counters are kept.
        state_q <= S_IDLE;
        init_q  <= '0;
        busy_q  <= 1'b0;
      end else begin
        unique case (state_q)
          S_IDLE: begin
            // abort_i also blocks a start in idle so a coincident abort wins.
            if (start_i && !abort_i) begin
              mask_q  <= test_mask_i;
              pass_q  <= '0;
              fail_q  <= '0;
              tmo_q   <= '0;
              idx_q   <= '0;
              busy_q  <= 1'b1;
              state_q <= S_SCAN;
            end
          end

          S_SCAN: begin
            if (idx_q == IDXF_W'(NTESTS)) begin
              // Flags are final here, so the loop counters update on entry.
              state_q <= S_DONE;
              done_q  <= 1'b1;
              if (loops_done_q != '1)
                loops_done_q <= loops_done_q + LOOPCNT_W'(1);
              if (|fail_q && loops_failed_q != '1)
                loops_failed_q <= loops_failed_q + LOOPCNT_W'(1);
            end else begin
              cur_q <= idx_lo_d;
              if (!mask_q[idx_lo_d]) begin
                idx_q <= idx_q + IDXF_W'(1);
              end else begin
                init_q  <= onehot_d;
                cnt_q   <= '0;
                state_q <= S_LAUNCH;
              end
            end
          end

          S_LAUNCH: begin
            // init_q rose on entry, so it is high for exactly INIT_CYC cycles.
            if (cnt_q == CNT_W'(INIT_CYC - 1)) begin
              init_q  <= '0;
              cnt_q   <= '0;
              state_q <= S_ACK;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end

          S_ACK: begin
            // A progress line already high on entry counts as the ack.
            if (prog_s_q[idx_lo_d]) begin
              run_cnt_q <= '0;
              state_q   <= S_RUN;
            end else if (cnt_q == CNT_W'(ACK_TMO - 1)) begin
              tmo_q[idx_lo_d]  <= 1'b1;
              fail_q[idx_lo_d] <= 1'b1;
              state_q          <= S_NEXT;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end

          S_RUN: begin
            // Progress was high on entry, so low here is the falling edge.
            if (!prog_s_q[idx_lo_d]) begin
              pass_q[idx_lo_d] <= res_s_q[idx_lo_d];
              fail_q[idx_lo_d] <= ~res_s_q[idx_lo_d];
              state_q          <= S_NEXT;
            end else if (run_cnt_q == '1) begin
              tmo_q[idx_lo_d]  <= 1'b1;
              fail_q[idx_lo_d] <= 1'b1;
              state_q          <= S_NEXT;
            end else begin
              run_cnt_q <= run_cnt_q + RUN_TMO_W'(1);
            end
          end

          S_NEXT: begin
            idx_q   <= idx_q + IDXF_W'(1);
            state_q <= S_SCAN;
          end

          S_DONE: begin
            if (loop_en_i) begin
              mask_q  <= test_mask_i;
              pass_q  <= '0;
              fail_q  <= '0;
              tmo_q   <= '0;
              idx_q   <= '0;
              state_q <= S_SCAN;
            end else begin
              busy_q  <= 1'b0;
              state_q <= S_IDLE;
            end
          end

          default: begin
            init_q  <= '0;
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign test_init_o    = init_q;
  assign busy_o         = busy_q;
  assign done_o         = done_q;
  assign cur_test_o     = cur_q;
  assign pass_flags_o   = pass_q;
  assign fail_flags_o   = fail_q;
  assign tmo_flags_o    = tmo_q;
  assign loops_done_o   = loops_done_q;
  assign loops_failed_o = loops_failed_q;

endmodule
